fractal_sync_tx: RTL and testbench

- Core-side initiator of the fractal synchronization protocol, one instance per core/tile port.
- Accepts a barrier request (level, id) from the core and issues one synch request toward the local RF tree.
- Stamps the request with the port's source-direction (sd).
- Holds the core until the matching synch response returns, then pulses done with an error flag.
- Single outstanding barrier per instance.

---
 rtl/fractal_sync_pkg.sv | 24 ++
 rtl/fractal_sync_tx_timer.sv | 41 ++++
 rtl/fractal_sync_tx.sv | 188 ++++++++++++++++++
 tb/tb_fractal_sync_tx.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fractal_sync_pkg.sv
// -----------------------------------------------------------------------------
// fractal_sync_pkg
// Shared definitions for the fractal synchronization blocks.
//   SD_WIDTH                 width of the source-direction field
//   SD_*                     source-direction encodings stamped on requests
//   fractal_sync_tx_state_e  state encoding of the core-side initiator FSM
// -----------------------------------------------------------------------------
package fractal_sync_pkg;

    localparam int unsigned SD_WIDTH = 2;

    localparam logic [SD_WIDTH-1:0] SD_NONE = 2'd0;
    localparam logic [SD_WIDTH-1:0] SD_HORZ = 2'd1;
    localparam logic [SD_WIDTH-1:0] SD_VERT = 2'd2;
    localparam logic [SD_WIDTH-1:0] SD_BOTH = 2'd3;

    typedef enum logic [1:0] {
        TX_IDLE = 2'd0,
        TX_SEND = 2'd1,
        TX_WAIT = 2'd2,
        TX_RSP  = 2'd3
    } fractal_sync_tx_state_e;

endpackage

// File: rtl/fractal_sync_tx_timer.sv
// -----------------------------------------------------------------------------
// fractal_sync_tx_timer
// Clear/enable cycle counter that flags when a bounded wait has run out.
// Only instantiated when FRACTAL_SYNC_TX_TIMEOUT_EN is defined.
// Ports:
//   clk_i, rst_i  clock, asynchronous active-high reset
//   clear_i       synchronous clear (priority over enable)
//   enable_i      count one cycle
//   expired_o     count has reached TIMEOUT_CYCLES-1 while enabled
// -----------------------------------------------------------------------------
module fractal_sync_tx_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count_q;
    logic          at_last;

    assign at_last   = (count_q == LAST);
    assign expired_o = enable_i & at_last;

    // Saturates at LAST so the counter can never wrap if the owner lingers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else if (clear_i) begin
            count_q <= '0;
        end else if (enable_i && !at_last) begin
            count_q <= count_q + 1'b1;
        end
    end

endmodule

// File: rtl/fractal_sync_tx.sv
// -----------------------------------------------------------------------------
// fractal_sync_tx
// Core-side initiator of the fractal synchronization protocol. Takes one
// barrier request (level, id) from the core, issues a single synch request
// toward the local RF tree stamped with this port's source direction, and
// holds the core until the matching response returns; then pulses done_o
// with err_o. One outstanding barrier at a time.
//
// Optional build macro: FRACTAL_SYNC_TX_TIMEOUT_EN bounds the wait for a
// response to TIMEOUT_CYCLES cycles (completion with err_o=1, timeout_o=1).
//
// Ports:
//   clk_i, rst_i                      clock, asynchronous active-high reset
//   req_valid_i/req_ready_o           core request handshake
//   req_level_i, req_id_i             requested barrier level / id
//   done_o, err_o, timeout_o          one-cycle completion pulse + qualifiers
//   sync_valid_o/sync_ready_i         network request handshake
//   sync_level_o, sync_id_o, sync_sd_o outstanding request fields
//   rsp_valid_i, rsp_level_i,
//   rsp_id_i, rsp_err_i               network response (always accepted)
//   spurious_o                        response that matched nothing
//   dbg_state_o                       current FSM state
//
// Handshakes: a transfer happens on a cycle where valid and ready are both
// high. Once sync_valid_o rises its fields stay constant and it does not drop
// until sync_ready_i is seen. req_valid_i is only looked at while
// req_ready_o=1. Responses have no ready and are consumed on rsp_valid_i.
// -----------------------------------------------------------------------------
module fractal_sync_tx
    import fractal_sync_pkg::*;
#(
    parameter int unsigned          LVL_WIDTH      = 4,
    parameter int unsigned          ID_WIDTH       = 4,
    parameter logic [SD_WIDTH-1:0]  SD             = SD_HORZ,
    parameter int unsigned          TIMEOUT_CYCLES = 1024
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic [LVL_WIDTH-1:0]   req_level_i,
    input  logic [ID_WIDTH-1:0]    req_id_i,
    output logic                   done_o,
    output logic                   err_o,
    output logic                   sync_valid_o,
    input  logic                   sync_ready_i,
    output logic [LVL_WIDTH-1:0]   sync_level_o,
    output logic [ID_WIDTH-1:0]    sync_id_o,
    output logic [SD_WIDTH-1:0]    sync_sd_o,
    input  logic                   rsp_valid_i,
    input  logic [LVL_WIDTH-1:0]   rsp_level_i,
    input  logic [ID_WIDTH-1:0]    rsp_id_i,
    input  logic                   rsp_err_i,
    output logic                   spurious_o,
    output logic                   timeout_o,
    output fractal_sync_tx_state_e dbg_state_o
);

    fractal_sync_tx_state_e state_q, state_d;

    logic [LVL_WIDTH-1:0] level_q;
    logic [ID_WIDTH-1:0]  id_q;
    logic                 err_q;
    logic                 timeout_q;

    logic accept;
    logic rsp_match;
    logic expired;

    assign accept    = req_valid_i & req_ready_o;
    // Full id compare, H/V selector bit included.
    assign rsp_match = rsp_valid_i && (rsp_level_i == level_q) && (rsp_id_i == id_q);

    assign sync_sd_o   = SD;
    assign dbg_state_o = state_q;

`ifdef FRACTAL_SYNC_TX_TIMEOUT_EN
    // Counter runs only in WAIT and is held at zero everywhere else, so it
    // starts from zero on every entry to WAIT.
    fractal_sync_tx_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clear_i   (state_q != TX_WAIT),
        .enable_i  (state_q == TX_WAIT),
        .expired_o (expired)
    );
`else
    localparam int unsigned TIMEOUT_UNUSED = TIMEOUT_CYCLES;
    assign expired = 1'b0;
`endif

    // ---------------------------------------------------------------- state reg
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= TX_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // --------------------------------------------------------------- next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            TX_IDLE: begin
                if (accept) begin
                    // Level 0 is illegal: complete with error, never touch the network.
                    state_d = (req_level_i == '0) ? TX_RSP : TX_SEND;
                end
            end
            TX_SEND: begin
                if (sync_ready_i) begin
                    state_d = TX_WAIT;
                end
            end
            TX_WAIT: begin
                // A match on the expiry cycle completes normally.
                if (rsp_match || expired) begin
                    state_d = TX_RSP;
                end
            end
            TX_RSP: begin
                state_d = TX_IDLE;
            end
            default: begin
                state_d = TX_IDLE;
            end
        endcase
    end

    // ----------------------------------------------------- latched barrier data
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            level_q   <= '0;
            id_q      <= '0;
            err_q     <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            if ((state_q == TX_IDLE) && accept) begin
                level_q   <= req_level_i;
                id_q      <= req_id_i;
                err_q     <= (req_level_i == '0);
                timeout_q <= 1'b0;
            end else if (state_q == TX_WAIT) begin
                if (rsp_match) begin
                    err_q     <= rsp_err_i;
                    timeout_q <= 1'b0;
                end else if (expired) begin
                    err_q     <= 1'b1;
                    timeout_q <= 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------ outputs
    always_comb begin
        req_ready_o  = 1'b0;
        sync_valid_o = 1'b0;
        sync_level_o = '0;
        sync_id_o    = '0;
        done_o       = 1'b0;
        err_o        = 1'b0;
        timeout_o    = 1'b0;
        unique case (state_q)
            TX_IDLE: begin
                req_ready_o = 1'b1;
            end
            TX_SEND: begin
                sync_valid_o = 1'b1;
                sync_level_o = level_q;
                sync_id_o    = id_q;
            end
            TX_RSP: begin
                done_o    = 1'b1;
                err_o     = err_q;
                timeout_o = timeout_q;
            end
            default: begin
            end
        endcase
        // Any response that does not complete the outstanding barrier is dropped.
        spurious_o = rsp_valid_i & ~((state_q == TX_WAIT) & rsp_match);
    end

endmodule

// File: tb/tb_fractal_sync_tx.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_fractal_sync_tx
// Self-checking bench for fractal_sync_tx: directed protocol scenarios plus a
// randomized loop. Completions and network requests are predicted into queues
// when stimulus is driven and popped by a monitor when the DUT produces them.
// Timeout scenarios run when FRACTAL_SYNC_TX_TIMEOUT_EN is defined.
// -----------------------------------------------------------------------------
module tb_fractal_sync_tx;
    import fractal_sync_pkg::*;

    localparam int LW = 4;
    localparam int IW = 4;
    localparam int TO = 8;
    localparam logic [SD_WIDTH-1:0] EXP_SD = SD_VERT;

    // ------------------------------------------------------- clock and reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          req_valid, req_ready;
    logic [LW-1:0] req_level;
    logic [IW-1:0] req_id;
    logic          done, err, timeout, spurious;
    logic          sync_valid, sync_ready;
    logic [LW-1:0] sync_level;
    logic [IW-1:0] sync_id;
    logic [SD_WIDTH-1:0] sync_sd;
    logic          rsp_valid, rsp_err;
    logic [LW-1:0] rsp_level;
    logic [IW-1:0] rsp_id;
    fractal_sync_tx_state_e dbg_state;

    fractal_sync_tx #(
        .LVL_WIDTH      (LW),
        .ID_WIDTH       (IW),
        .SD             (EXP_SD),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_level_i  (req_level),
        .req_id_i     (req_id),
        .done_o       (done),
        .err_o        (err),
        .sync_valid_o (sync_valid),
        .sync_ready_i (sync_ready),
        .sync_level_o (sync_level),
        .sync_id_o    (sync_id),
        .sync_sd_o    (sync_sd),
        .rsp_valid_i  (rsp_valid),
        .rsp_level_i  (rsp_level),
        .rsp_id_i     (rsp_id),
        .rsp_err_i    (rsp_err),
        .spurious_o   (spurious),
        .timeout_o    (timeout),
        .dbg_state_o  (dbg_state)
    );

    // ------------------------------------------------------------ scoreboard
    int n_checks = 0;
    int n_fail   = 0;
    int spur_seen = 0;
    int exp_spur  = 0;

    logic [1:0]       exp_done_q[$];   // {err, timeout}
    logic [LW+IW-1:0] exp_sync_q[$];   // {level, id}
    logic [1:0]       mon_done_e;
    logic [LW+IW-1:0] mon_sync_e;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (spurious) spur_seen++;
            if (done) begin
                if (exp_done_q.size() == 0) begin
                    check("unexpected_done", 32'(done), 32'(0));
                end else begin
                    mon_done_e = exp_done_q.pop_front();
                    check("done_err_timeout", 32'({err, timeout}), 32'(mon_done_e));
                end
            end
            if (sync_valid && sync_ready) begin
                if (exp_sync_q.size() == 0) begin
                    check("unexpected_sync", 32'(sync_valid), 32'(0));
                end else begin
                    mon_sync_e = exp_sync_q.pop_front();
                    check("sync_fields", 32'({sync_level, sync_id}), 32'(mon_sync_e));
                end
            end
        end
    end

    // ---------------------------------------------------------- driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    // Starts at posedge+1 of an IDLE cycle, ends at posedge+1 of the next IDLE cycle.
    task automatic run_barrier(input logic [LW-1:0] lvl, input logic [IW-1:0] id,
                               input int bp, input int rsp_delay, input bit spur,
                               input logic [LW-1:0] lvl_flip, input logic [IW-1:0] id_flip,
                               input bit rerr);
        int n_wait;
        bit is_spur, last;
        // cycle 0: request offered in IDLE
        req_valid = 1'b1; req_level = lvl; req_id = id; sync_ready = 1'b0;
        sample();
        check("req_ready_idle", 32'(req_ready), 32'(1));
        if (lvl == '0) exp_done_q.push_back(2'b10);
        else exp_sync_q.push_back({lvl, id});
        step();
        // scramble request inputs to prove the fields were latched
        req_valid = 1'b0; req_level = LW'($urandom); req_id = IW'($urandom);
        if (lvl == '0) begin
            sample();
            check("illegal_no_sync", 32'(sync_valid), 32'(0));
            check("illegal_done", 32'(done), 32'(1));
            check("illegal_err", 32'(err), 32'(1));
            check("illegal_ready", 32'(req_ready), 32'(0));
            step();
            sample();
            check("ready_after_rsp", 32'(req_ready), 32'(1));
            check("done_cleared", 32'(done), 32'(0));
            step();
            return;
        end
        // SEND: bp cycles without ready, then one with ready
        for (int i = 0; i <= bp; i++) begin
            sync_ready = (i == bp);
            sample();
            check("sync_valid_held", 32'(sync_valid), 32'(1));
            check("sync_level_stable", 32'(sync_level), 32'(lvl));
            check("sync_id_stable", 32'(sync_id), 32'(id));
            check("sync_sd", 32'(sync_sd), 32'(EXP_SD));
            check("ready_low_send", 32'(req_ready), 32'(0));
            check("state_send", 32'(dbg_state), 32'(TX_SEND));
            step();
        end
        sync_ready = 1'b0;
        exp_done_q.push_back({rerr, 1'b0});
        // WAIT: idle cycles, optional non-matching response, then the match
        n_wait = rsp_delay + (spur ? 1 : 0) + 1;
        for (int i = 0; i < n_wait; i++) begin
            last    = (i == n_wait - 1);
            is_spur = spur && (i == n_wait - 2);
            rsp_valid = last || is_spur;
            rsp_level = is_spur ? (lvl ^ lvl_flip) : lvl;
            rsp_id    = is_spur ? (id ^ id_flip) : id;
            rsp_err   = last ? rerr : 1'($urandom);
            if (is_spur) exp_spur++;
            sample();
            check("state_wait", 32'(dbg_state), 32'(TX_WAIT));
            check("no_sync_in_wait", 32'(sync_valid), 32'(0));
            check("no_done_in_wait", 32'(done), 32'(0));
            check("spurious_in_wait", 32'(spurious), 32'(is_spur));
            step();
        end
        rsp_valid = 1'b0;
        sample();
        check("done_pulse", 32'(done), 32'(1));
        check("done_err", 32'(err), 32'(rerr));
        check("done_timeout", 32'(timeout), 32'(0));
        check("ready_low_rsp", 32'(req_ready), 32'(0));
        step();
        sample();
        check("ready_after_rsp", 32'(req_ready), 32'(1));
        check("done_cleared", 32'(done), 32'(0));
        step();
    endtask

`ifdef FRACTAL_SYNC_TX_TIMEOUT_EN
    task automatic run_timeout(input bit match_at_expiry);
        req_valid = 1'b1; req_level = 4'd3; req_id = 4'd9; sync_ready = 1'b1;
        exp_sync_q.push_back({4'd3, 4'd9});
        sample();
        step();
        req_valid = 1'b0;
        sample();
        step();
        sync_ready = 1'b0;
        exp_done_q.push_back(match_at_expiry ? 2'b00 : 2'b11);
        for (int i = 0; i < TO; i++) begin
            rsp_valid = match_at_expiry && (i == TO - 1);
            rsp_level = 4'd3; rsp_id = 4'd9; rsp_err = 1'b0;
            sample();
            check("to_state_wait", 32'(dbg_state), 32'(TX_WAIT));
            check("to_no_early_done", 32'(done), 32'(0));
            step();
        end
        rsp_valid = 1'b0;
        sample();
        check("to_done", 32'(done), 32'(1));
        check("to_err", 32'(err), 32'(!match_at_expiry));
        check("to_timeout", 32'(timeout), 32'(!match_at_expiry));
        step();
        sample();
        check("to_ready_after", 32'(req_ready), 32'(1));
        step();
    endtask
`endif

    // ------------------------------------------------------------- watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "watchdog expired");
    end

    // --------------------------------------------------------------- main
    initial begin
        logic [LW-1:0] r_lvl, r_lflip;
        logic [IW-1:0] r_id, r_iflip;
        bit r_spur;
        req_valid = 1'b0; req_level = '0; req_id = '0;
        sync_ready = 1'b0;
        rsp_valid = 1'b0; rsp_level = '0; rsp_id = '0; rsp_err = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        sample();
        check("rst_state", 32'(dbg_state), 32'(TX_IDLE));
        check("rst_req_ready", 32'(req_ready), 32'(1));
        check("rst_sync_valid", 32'(sync_valid), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        check("rst_err", 32'(err), 32'(0));
        check("rst_timeout", 32'(timeout), 32'(0));
        check("rst_spurious", 32'(spurious), 32'(0));
        check("rst_sync_sd", 32'(sync_sd), 32'(EXP_SD));
        check("rst_sync_level", 32'(sync_level), 32'(0));
        step();
        rst = 1'b0;

        // basic, backpressure, illegal level, spurious (H/V bit) + error, level mismatch
        run_barrier(4'd2, 4'd5, 0, 0, 1'b0, 4'd0, 4'd0, 1'b0);
        run_barrier(4'd2, 4'd5, 5, 0, 1'b0, 4'd0, 4'd0, 1'b0);
        run_barrier(4'd0, 4'd3, 0, 0, 1'b0, 4'd0, 4'd0, 1'b0);
        run_barrier(4'd2, 4'd5, 0, 1, 1'b1, 4'd0, 4'd1, 1'b1);
        run_barrier(4'd7, 4'd12, 1, 2, 1'b1, 4'd4, 4'd0, 1'b0);

        // response while IDLE is spurious and leaves the block idle
        rsp_valid = 1'b1; rsp_level = 4'd2; rsp_id = 4'd5; rsp_err = 1'b0;
        exp_spur++;
        sample();
        check("idle_spurious", 32'(spurious), 32'(1));
        step();
        rsp_valid = 1'b0;
        sample();
        check("idle_after_spurious", 32'(dbg_state), 32'(TX_IDLE));
        check("idle_no_done", 32'(done), 32'(0));
        step();

        // reset while waiting drops the barrier; its late response is spurious
        req_valid = 1'b1; req_level = 4'd2; req_id = 4'd5; sync_ready = 1'b1;
        exp_sync_q.push_back({4'd2, 4'd5});
        sample();
        step();
        req_valid = 1'b0;
        sample();
        step();
        sync_ready = 1'b0;
        sample();
        check("pre_reset_wait", 32'(dbg_state), 32'(TX_WAIT));
        #2 rst = 1'b1;
        #1;
        check("async_rst_state", 32'(dbg_state), 32'(TX_IDLE));
        check("async_rst_ready", 32'(req_ready), 32'(1));
        step();
        step();
        rst = 1'b0;
        rsp_valid = 1'b1; rsp_level = 4'd2; rsp_id = 4'd5; rsp_err = 1'b0;
        exp_spur++;
        sample();
        check("late_rsp_spurious", 32'(spurious), 32'(1));
        check("late_rsp_no_done", 32'(done), 32'(0));
        step();
        rsp_valid = 1'b0;
        sample();
        check("late_rsp_idle", 32'(dbg_state), 32'(TX_IDLE));
        check("late_rsp_no_done2", 32'(done), 32'(0));
        step();

`ifdef FRACTAL_SYNC_TX_TIMEOUT_EN
        run_timeout(1'b0);
        run_timeout(1'b1);
`endif

        // randomized barriers
        for (int n = 0; n < 25; n++) begin
            r_lvl = ($urandom_range(0, 4) == 0) ? 4'd0 : LW'($urandom_range(1, 15));
            r_id  = IW'($urandom_range(0, 15));
            r_spur = 1'($urandom_range(0, 1));
            r_lflip = '0;
            r_iflip = '0;
            if ($urandom_range(0, 1) == 1) r_iflip[$urandom_range(0, IW - 1)] = 1'b1;
            else r_lflip[$urandom_range(0, LW - 1)] = 1'b1;
            run_barrier(r_lvl, r_id, $urandom_range(0, 3), $urandom_range(0, 4),
                        r_spur, r_lflip, r_iflip, 1'($urandom_range(0, 1)));
        end

        repeat (2) step();
        check("done_queue_drained", 32'(exp_done_q.size()), 32'(0));
        check("sync_queue_drained", 32'(exp_sync_q.size()), 32'(0));
        check("spurious_total", 32'(spur_seen), 32'(exp_spur));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
